// File: rtl/alu_issue_seq_pkg.sv
// Shared definitions for the ALU issue sequencer: opcode values, instruction
// word field positions, FSM state encoding and the opcode legality decode.
package alu_issue_seq_pkg;

    localparam int INSTR_W = 16;
    localparam int DATA_W  = 16;
    localparam int OPC_W   = 8;
    localparam int REG_AW  = 4;

    // Instruction word: [15:8] opcode, [7:4] rdest, [3:0] rsrc
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 8;
    localparam int RD_HI  = 7;
    localparam int RD_LO  = 4;
    localparam int RS_HI  = 3;
    localparam int RS_LO  = 0;

    localparam logic [OPC_W-1:0] OP_AND  = 8'h01;
    localparam logic [OPC_W-1:0] OP_OR   = 8'h02;
    localparam logic [OPC_W-1:0] OP_XOR  = 8'h03;
    localparam logic [OPC_W-1:0] OP_NOT  = 8'h04;
    localparam logic [OPC_W-1:0] OP_ADD  = 8'h05;
    localparam logic [OPC_W-1:0] OP_ADDU = 8'h06;
    localparam logic [OPC_W-1:0] OP_ADDC = 8'h07;
    localparam logic [OPC_W-1:0] OP_RSH  = 8'h08;
    localparam logic [OPC_W-1:0] OP_SUB  = 8'h09;
    localparam logic [OPC_W-1:0] OP_SUBC = 8'h0A;
    localparam logic [OPC_W-1:0] OP_CMP  = 8'h0B;
    localparam logic [OPC_W-1:0] OP_ALSH = 8'h0C;
    localparam logic [OPC_W-1:0] OP_MULT = 8'h0E;
    localparam logic [OPC_W-1:0] OP_ARSH = 8'h0F;
    localparam logic [OPC_W-1:0] OP_LSH  = 8'h84;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADD, OP_ADDU, OP_ADDC, OP_RSH,
            OP_SUB, OP_SUBC, OP_CMP, OP_ALSH, OP_MULT, OP_ARSH, OP_LSH: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Register file for the issue sequencer: one write port, three asynchronous
// read ports (rdest, rsrc, debug); the whole array clears on reset.
module alu_issue_regfile
    import alu_issue_seq_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_AW-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [REG_AW-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic [REG_AW-1:0] i_raddr_dbg,
    output logic [DATA_W-1:0] o_rdata_dbg
);

    logic [DATA_W-1:0] r_mem [NUM_REGS];

    // Flop array rather than RAM: every entry must clear in a single reset cycle.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        always_ff @(posedge clock) begin
            if (!reset) begin
                r_mem[gi] <= '0;
            end else if (i_we && (i_waddr == REG_AW'(gi))) begin
                r_mem[gi] <= i_wdata;
            end
        end
    end

    assign o_rdata_a   = r_mem[i_raddr_a];
    assign o_rdata_b   = r_mem[i_raddr_b];
    assign o_rdata_dbg = r_mem[i_raddr_dbg];

endmodule

// File: rtl/alu_issue_seq.sv
// Issue sequencer: accepts instruction words, reads operands, drives the external
// combinational ALU, samples its result after EXEC_CYCLES and writes it back.
module alu_issue_seq
    import alu_issue_seq_pkg::*;
#(
    parameter int EXEC_CYCLES = 1,
    parameter int NUM_REGS    = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr_data,
    output logic               instr_ready,
    output logic [DATA_W-1:0]  alu_r1,
    output logic [DATA_W-1:0]  alu_r2,
    output logic [OPC_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0]  alu_rout,
    output logic               wb_valid,
    output logic [REG_AW-1:0]  wb_addr,
    output logic [DATA_W-1:0]  wb_data,
    output logic               illegal,
    output logic               busy,
    input  logic               dbg_we,
    input  logic [REG_AW-1:0]  dbg_addr,
    input  logic [DATA_W-1:0]  dbg_wdata,
    output logic [DATA_W-1:0]  dbg_rdata
);

    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] w_instr_next;
    logic [DATA_W-1:0]  r_alu_r1;
    logic [DATA_W-1:0]  w_alu_r1_next;
    logic [DATA_W-1:0]  r_alu_r2;
    logic [DATA_W-1:0]  w_alu_r2_next;
    logic [OPC_W-1:0]   r_alu_opcode;
    logic [OPC_W-1:0]   w_alu_opcode_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [DATA_W-1:0]  r_result;
    logic [DATA_W-1:0]  w_result_next;
    logic               r_wb_valid;
    logic               w_wb_valid_next;
    logic [REG_AW-1:0]  r_wb_addr;
    logic [REG_AW-1:0]  w_wb_addr_next;
    logic [DATA_W-1:0]  r_wb_data;
    logic [DATA_W-1:0]  w_wb_data_next;
    logic               r_illegal;
    logic               w_illegal_next;

    logic [OPC_W-1:0]   w_opc;
    logic [REG_AW-1:0]  w_rdest;
    logic [REG_AW-1:0]  w_rsrc;
    logic [DATA_W-1:0]  w_rd_val;
    logic [DATA_W-1:0]  w_rs_val;
    logic               w_rf_we;
    logic [REG_AW-1:0]  w_rf_waddr;
    logic [DATA_W-1:0]  w_rf_wdata;

    assign w_opc   = r_instr[OPC_HI:OPC_LO];
    assign w_rdest = r_instr[RD_HI:RD_LO];
    assign w_rsrc  = r_instr[RS_HI:RS_LO];

    alu_issue_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clock       (clock),
        .reset       (reset),
        .i_we        (w_rf_we),
        .i_waddr     (w_rf_waddr),
        .i_wdata     (w_rf_wdata),
        .i_raddr_a   (w_rdest),
        .o_rdata_a   (w_rd_val),
        .i_raddr_b   (w_rsrc),
        .o_rdata_b   (w_rs_val),
        .i_raddr_dbg (dbg_addr),
        .o_rdata_dbg (dbg_rdata)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_instr_next      = r_instr;
        w_alu_r1_next     = r_alu_r1;
        w_alu_r2_next     = r_alu_r2;
        w_alu_opcode_next = r_alu_opcode;
        w_cnt_next        = r_cnt;
        w_result_next     = r_result;
        w_wb_valid_next   = 1'b0;
        w_wb_addr_next    = r_wb_addr;
        w_wb_data_next    = r_wb_data;
        w_illegal_next    = 1'b0;
        w_rf_we           = 1'b0;
        w_rf_waddr        = dbg_addr;
        w_rf_wdata        = dbg_wdata;

        case (r_state)
            ST_IDLE: begin
                // Preload and accept may share an edge; READ then sees the preload.
                w_rf_we = dbg_we;
                if (instr_valid) begin
                    w_instr_next = instr_data;
                    w_state_next = ST_READ;
                end
            end
            ST_READ: begin
                if (is_legal_op(w_opc)) begin
                    w_alu_r1_next     = w_rd_val;
                    w_alu_r2_next     = w_rs_val;
                    w_alu_opcode_next = w_opc;
                    w_cnt_next        = CNT_LOAD;
                    w_state_next      = ST_EXEC;
                end else begin
                    w_illegal_next = 1'b1;
                    w_state_next   = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (r_cnt == '0) begin
                    w_result_next = alu_rout;
                    w_state_next  = ST_WB;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_WB: begin
                // CMP only sets ALU-side flags, so its result is discarded.
                if (w_opc != OP_CMP) begin
                    w_rf_we         = 1'b1;
                    w_rf_waddr      = w_rdest;
                    w_rf_wdata      = r_result;
                    w_wb_valid_next = 1'b1;
                    w_wb_addr_next  = w_rdest;
                    w_wb_data_next  = r_result;
                end
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_instr      <= '0;
            r_alu_r1     <= '0;
            r_alu_r2     <= '0;
            r_alu_opcode <= '0;
            r_cnt        <= '0;
            r_result     <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_addr    <= '0;
            r_wb_data    <= '0;
            r_illegal    <= 1'b0;
        end else begin
            r_instr      <= w_instr_next;
            r_alu_r1     <= w_alu_r1_next;
            r_alu_r2     <= w_alu_r2_next;
            r_alu_opcode <= w_alu_opcode_next;
            r_cnt        <= w_cnt_next;
            r_result     <= w_result_next;
            r_wb_valid   <= w_wb_valid_next;
            r_wb_addr    <= w_wb_addr_next;
            r_wb_data    <= w_wb_data_next;
            r_illegal    <= w_illegal_next;
        end
    end

    assign instr_ready = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign alu_r1      = r_alu_r1;
    assign alu_r2      = r_alu_r2;
    assign alu_opcode  = r_alu_opcode;
    assign wb_valid    = r_wb_valid;
    assign wb_addr     = r_wb_addr;
    assign wb_data     = r_wb_data;
    assign illegal     = r_illegal;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: two instances (EXEC_CYCLES=1 and 3) driven in turn,
// with a stand-in ALU on the alu_* ports and a write-back scoreboard queue.
module tb_alu_issue_seq;

    logic        clk;
    logic        rst_n       [2];
    logic        instr_valid [2];
    logic [15:0] instr_data  [2];
    logic        instr_ready [2];
    logic [15:0] alu_r1      [2];
    logic [15:0] alu_r2      [2];
    logic [7:0]  alu_opcode  [2];
    logic [15:0] alu_rout    [2];
    logic        wb_valid    [2];
    logic [3:0]  wb_addr     [2];
    logic [15:0] wb_data     [2];
    logic        illegal     [2];
    logic        busy        [2];
    logic        dbg_we      [2];
    logic [3:0]  dbg_addr    [2];
    logic [15:0] dbg_wdata   [2];
    logic [15:0] dbg_rdata   [2];

    int n_vec = 0;
    int n_bad = 0;
    logic [20:0] sb_q [$];  // {instance, wb_addr, wb_data}

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] alu_model(input logic [7:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
        case (op)
            8'h01:   return a & b;
            8'h02:   return a | b;
            8'h03:   return a ^ b;
            8'h05:   return a + b;
            8'h0B:   return a - b;
            default: return a ^ b ^ 16'h5A5A;
        endcase
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        alu_issue_seq #(
            .EXEC_CYCLES ((gi == 0) ? 1 : 3),
            .NUM_REGS    (16)
        ) u_dut (
            .clock       (clk),
            .reset       (rst_n[gi]),
            .instr_valid (instr_valid[gi]),
            .instr_data  (instr_data[gi]),
            .instr_ready (instr_ready[gi]),
            .alu_r1      (alu_r1[gi]),
            .alu_r2      (alu_r2[gi]),
            .alu_opcode  (alu_opcode[gi]),
            .alu_rout    (alu_rout[gi]),
            .wb_valid    (wb_valid[gi]),
            .wb_addr     (wb_addr[gi]),
            .wb_data     (wb_data[gi]),
            .illegal     (illegal[gi]),
            .busy        (busy[gi]),
            .dbg_we      (dbg_we[gi]),
            .dbg_addr    (dbg_addr[gi]),
            .dbg_wdata   (dbg_wdata[gi]),
            .dbg_rdata   (dbg_rdata[gi])
        );
        assign alu_rout[gi] = alu_model(alu_opcode[gi], alu_r1[gi], alu_r2[gi]);
    end

    task automatic test_reset(input int k);
        @(negedge clk);
        rst_n[k] = 1'b0;
        instr_valid[k] = 1'b0;
        dbg_we[k] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++; if (alu_r1[k] !== 16'h0) begin n_bad++; $display("FAIL rst_alu_r1 k=%0d got=%h exp=0000", k, alu_r1[k]); end
        n_vec++; if (alu_r2[k] !== 16'h0) begin n_bad++; $display("FAIL rst_alu_r2 k=%0d got=%h exp=0000", k, alu_r2[k]); end
        n_vec++; if (alu_opcode[k] !== 8'h0) begin n_bad++; $display("FAIL rst_alu_opcode k=%0d got=%h exp=00", k, alu_opcode[k]); end
        n_vec++; if (wb_valid[k] !== 1'b0) begin n_bad++; $display("FAIL rst_wb_valid k=%0d got=%b exp=0", k, wb_valid[k]); end
        n_vec++; if (wb_addr[k] !== 4'h0) begin n_bad++; $display("FAIL rst_wb_addr k=%0d got=%h exp=0", k, wb_addr[k]); end
        n_vec++; if (wb_data[k] !== 16'h0) begin n_bad++; $display("FAIL rst_wb_data k=%0d got=%h exp=0000", k, wb_data[k]); end
        n_vec++; if (illegal[k] !== 1'b0) begin n_bad++; $display("FAIL rst_illegal k=%0d got=%b exp=0", k, illegal[k]); end
        n_vec++; if (busy[k] !== 1'b0) begin n_bad++; $display("FAIL rst_busy k=%0d got=%b exp=0", k, busy[k]); end
        n_vec++; if (instr_ready[k] !== 1'b1) begin n_bad++; $display("FAIL rst_instr_ready k=%0d got=%b exp=1", k, instr_ready[k]); end
        for (int a = 0; a < 16; a++) begin
            dbg_addr[k] = 4'(a);
            #1;
            n_vec++;
            if (dbg_rdata[k] !== 16'h0) begin
                n_bad++; $display("FAIL rst_dbg_rdata k=%0d addr=%0d got=%h exp=0000", k, a, dbg_rdata[k]);
            end
        end
        @(negedge clk);
        rst_n[k] = 1'b1;
        $display("reset k=%0d done", k);
    endtask

    // Preload of R2 shares the accept edge; READ must see the preloaded value.
    task automatic test_add(input int k);
        int ex;
        logic [20:0] e;
        ex = (k == 0) ? 1 : 3;
        @(negedge clk);
        dbg_we[k] = 1'b1; dbg_addr[k] = 4'd1; dbg_wdata[k] = 16'd1;
        @(negedge clk);
        dbg_addr[k] = 4'd2;
        instr_valid[k] = 1'b1; instr_data[k] = 16'h0512;
        sb_q.push_back({k[0], 4'd1, 16'd2});
        @(negedge clk);
        dbg_we[k] = 1'b0; instr_valid[k] = 1'b0;
        n_vec++; if (busy[k] !== 1'b1) begin n_bad++; $display("FAIL add_busy k=%0d got=%b exp=1", k, busy[k]); end
        for (int c = 1; c <= ex + 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_vec++; if (alu_r1[k] !== 16'd1) begin n_bad++; $display("FAIL add_alu_r1 k=%0d got=%h exp=0001", k, alu_r1[k]); end
                n_vec++; if (alu_r2[k] !== 16'd1) begin n_bad++; $display("FAIL add_alu_r2 k=%0d got=%h exp=0001", k, alu_r2[k]); end
                n_vec++; if (alu_opcode[k] !== 8'h05) begin n_bad++; $display("FAIL add_alu_opcode k=%0d got=%h exp=05", k, alu_opcode[k]); end
            end
            n_vec++;
            if (wb_valid[k] !== (c == 2 + ex)) begin
                n_bad++; $display("FAIL add_wb_timing k=%0d cyc=%0d got=%b exp=%b", k, c, wb_valid[k], (c == 2 + ex));
            end
            if (wb_valid[k] === 1'b1) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_bad++; $display("FAIL add_sb_empty k=%0d got wb addr=%h data=%h exp none", k, wb_addr[k], wb_data[k]);
                end else begin
                    e = sb_q.pop_front();
                    $display("wb k=%0d addr=%h data=%h", k, wb_addr[k], wb_data[k]);
                    if ({k[0], wb_addr[k], wb_data[k]} !== e) begin
                        n_bad++; $display("FAIL add_wb k=%0d got=%h/%h exp=%h/%h", k, wb_addr[k], wb_data[k], e[19:16], e[15:0]);
                    end
                end
            end
        end
        dbg_addr[k] = 4'd1;
        #1;
        n_vec++; if (dbg_rdata[k] !== 16'd2) begin n_bad++; $display("FAIL add_readback k=%0d got=%h exp=0002", k, dbg_rdata[k]); end
    endtask

    task automatic test_cmp(input int k);
        int ex;
        ex = (k == 0) ? 1 : 3;
        @(negedge clk);
        dbg_we[k] = 1'b1; dbg_addr[k] = 4'd3; dbg_wdata[k] = 16'd5;
        @(negedge clk);
        dbg_addr[k] = 4'd4;
        @(negedge clk);
        dbg_we[k] = 1'b0;
        instr_valid[k] = 1'b1; instr_data[k] = 16'h0B34;
        @(negedge clk);
        instr_valid[k] = 1'b0;
        for (int c = 1; c <= ex + 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_vec++; if (alu_opcode[k] !== 8'h0B) begin n_bad++; $display("FAIL cmp_alu_opcode k=%0d got=%h exp=0b", k, alu_opcode[k]); end
            end
            n_vec++;
            if (busy[k] !== (c <= 1 + ex)) begin
                n_bad++; $display("FAIL cmp_busy k=%0d cyc=%0d got=%b exp=%b", k, c, busy[k], (c <= 1 + ex));
            end
            n_vec++;
            if (wb_valid[k] !== 1'b0) begin
                n_bad++; $display("FAIL cmp_wb_valid k=%0d cyc=%0d got=%b exp=0", k, c, wb_valid[k]);
            end
        end
        dbg_addr[k] = 4'd3;
        #1;
        n_vec++; if (dbg_rdata[k] !== 16'd5) begin n_bad++; $display("FAIL cmp_r3 k=%0d got=%h exp=0005", k, dbg_rdata[k]); end
        $display("cmp k=%0d done", k);
    endtask

    task automatic test_illegal(input int k);
        @(negedge clk);
        instr_valid[k] = 1'b1; instr_data[k] = 16'h0D12;
        @(negedge clk);
        instr_valid[k] = 1'b0;
        n_vec++; if (busy[k] !== 1'b1) begin n_bad++; $display("FAIL ill_busy0 k=%0d got=%b exp=1", k, busy[k]); end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_vec++;
            if (illegal[k] !== (c == 1)) begin
                n_bad++; $display("FAIL ill_pulse k=%0d cyc=%0d got=%b exp=%b", k, c, illegal[k], (c == 1));
            end
            if (c == 1) begin
                n_vec++; if (busy[k] !== 1'b0) begin n_bad++; $display("FAIL ill_busy k=%0d got=%b exp=0", k, busy[k]); end
                n_vec++; if (alu_opcode[k] !== 8'h0B) begin n_bad++; $display("FAIL ill_alu_hold k=%0d got=%h exp=0b", k, alu_opcode[k]); end
            end
            n_vec++;
            if (wb_valid[k] !== 1'b0) begin
                n_bad++; $display("FAIL ill_wb_valid k=%0d cyc=%0d got=%b exp=0", k, c, wb_valid[k]);
            end
        end
        $display("illegal k=%0d done", k);
    endtask

    task automatic test_back_to_back(input int k);
        int ex;
        int n_pulse;
        int c_first;
        int c_second;
        logic [15:0] p1;
        logic [15:0] p2;
        logic [15:0] r_and;
        logic [20:0] e;
        ex = (k == 0) ? 1 : 3;
        p1 = 16'h00F0;
        p2 = 16'h0F0F;
        r_and = p1 & p2;
        n_pulse = 0; c_first = -1; c_second = -1;
        @(negedge clk);
        dbg_we[k] = 1'b1; dbg_addr[k] = 4'd1; dbg_wdata[k] = p1;
        @(negedge clk);
        dbg_addr[k] = 4'd2; dbg_wdata[k] = p2;
        @(negedge clk);
        dbg_we[k] = 1'b0;
        instr_valid[k] = 1'b1; instr_data[k] = 16'h0112;
        sb_q.push_back({k[0], 4'd1, r_and});
        sb_q.push_back({k[0], 4'd1, r_and | p2});
        @(negedge clk);
        instr_data[k] = 16'h0212;
        for (int c = 1; c <= 2 * (3 + ex) + 2; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_vec++; if (instr_ready[k] !== 1'b0) begin n_bad++; $display("FAIL b2b_ready k=%0d got=%b exp=0", k, instr_ready[k]); end
            end
            if (c == 3 + ex) instr_valid[k] = 1'b0;
            if (wb_valid[k] === 1'b1) begin
                n_pulse++;
                if (n_pulse == 1) c_first = c;
                if (n_pulse == 2) c_second = c;
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_bad++; $display("FAIL b2b_sb_empty k=%0d got wb addr=%h data=%h exp none", k, wb_addr[k], wb_data[k]);
                end else begin
                    e = sb_q.pop_front();
                    $display("wb k=%0d addr=%h data=%h", k, wb_addr[k], wb_data[k]);
                    if ({k[0], wb_addr[k], wb_data[k]} !== e) begin
                        n_bad++; $display("FAIL b2b_wb k=%0d got=%h/%h exp=%h/%h", k, wb_addr[k], wb_data[k], e[19:16], e[15:0]);
                    end
                end
            end
        end
        n_vec++; if (n_pulse != 2) begin n_bad++; $display("FAIL b2b_pulses k=%0d got=%0d exp=2", k, n_pulse); end
        n_vec++; if (c_first != 2 + ex) begin n_bad++; $display("FAIL b2b_first k=%0d got=%0d exp=%0d", k, c_first, 2 + ex); end
        n_vec++;
        if (c_second - c_first != 3 + ex) begin
            n_bad++; $display("FAIL b2b_spacing k=%0d got=%0d exp=%0d", k, c_second - c_first, 3 + ex);
        end
    endtask

    task automatic test_reset_mid_exec(input int k);
        @(negedge clk);
        dbg_we[k] = 1'b1; dbg_addr[k] = 4'd5; dbg_wdata[k] = 16'd7;
        @(negedge clk);
        dbg_addr[k] = 4'd6; dbg_wdata[k] = 16'd9;
        @(negedge clk);
        dbg_we[k] = 1'b0;
        instr_valid[k] = 1'b1; instr_data[k] = 16'h0556;
        @(negedge clk);
        instr_valid[k] = 1'b0;
        @(negedge clk);
        n_vec++; if (busy[k] !== 1'b1) begin n_bad++; $display("FAIL rme_in_exec k=%0d got=%b exp=1", k, busy[k]); end
        rst_n[k] = 1'b0;
        @(negedge clk);
        rst_n[k] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_vec++; if (wb_valid[k] !== 1'b0) begin n_bad++; $display("FAIL rme_wb_valid k=%0d cyc=%0d got=%b exp=0", k, c, wb_valid[k]); end
            n_vec++; if (busy[k] !== 1'b0) begin n_bad++; $display("FAIL rme_busy k=%0d cyc=%0d got=%b exp=0", k, c, busy[k]); end
            @(negedge clk);
        end
        for (int a = 0; a < 16; a++) begin
            dbg_addr[k] = 4'(a);
            #1;
            n_vec++;
            if (dbg_rdata[k] !== 16'h0) begin
                n_bad++; $display("FAIL rme_clear k=%0d addr=%0d got=%h exp=0000", k, a, dbg_rdata[k]);
            end
        end
        $display("reset_mid_exec k=%0d done", k);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0;
            instr_valid[k] = 1'b0;
            instr_data[k] = 16'h0;
            dbg_we[k] = 1'b0;
            dbg_addr[k] = 4'h0;
            dbg_wdata[k] = 16'h0;
        end
        for (int k = 0; k < 2; k++) begin
            test_reset(k);
            test_add(k);
            test_cmp(k);
            test_illegal(k);
            test_back_to_back(k);
            test_reset_mid_exec(k);
        end
        n_vec++;
        if (sb_q.size() != 0) begin
            n_bad++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
